// File: rtl/ahbl_sram_ctrl_pkg.sv
// Shared AHB-Lite definitions for on-chip AHB slaves.
//   htrans_e      : HTRANS transfer types
//   hsize_e       : HSIZE transfer sizes (values >= WORD are treated as word)
//   ahb_byte_mask : byte-lane enable for a size/address pair
package ahbl_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  // Low address bits beyond the transfer size are ignored (no alignment error).
  function automatic logic [3:0] ahb_byte_mask(input logic [2:0] size,
                                               input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite slave driving a single-port SRAM macro with zero wait states.
// Reads use the SRAM port in their address phase; writes use it in their
// data phase. When a write's data phase collides with a read address phase,
// the write is parked in a one-entry buffer and drained in the next cycle
// without a read. Reads to the parked word see the parked bytes via a merge.
// Ports:
//   HCLK, HRESET (sync, active high)
//   HSEL/HADDR/HTRANS/HWRITE/HSIZE/HREADY/HWDATA : AHB-Lite slave inputs
//   HREADYOUT (=1), HRESP (=OKAY), HRDATA        : AHB-Lite slave outputs
//   SRAMRDATA                                    : SRAM read data (1-cycle latency)
//   SRAMCS/SRAMWEN/SRAMADDR/SRAMWDATA            : SRAM macro port
module ahbl_sram_ctrl
  import ahbl_sram_ctrl_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS,
  output logic [AW-3:0] SRAMADDR
);

  logic          ap, ap_rd, ap_wr;
  logic          dp_rd, dp_wr;
  logic [AW-3:0] dp_addr;
  logic [3:0]    dp_mask;
  logic          buf_valid;
  logic [AW-3:0] buf_addr;
  logic [3:0]    buf_mask;
  logic [31:0]   buf_data;
  logic          buf_commit;
  logic          buf_hit;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:AW], HTRANS[0]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign ap    = HSEL & HTRANS[1] & HREADY;
  assign ap_rd = ap & ~HWRITE;
  assign ap_wr = ap &  HWRITE;

  // SRAM port arbitration: read address phase > direct write > buffer drain.
  always_comb begin
    SRAMCS     = 1'b0;
    SRAMWEN    = '0;
    SRAMADDR   = '0;
    SRAMWDATA  = '0;
    buf_commit = 1'b0;
    if (!HRESET) begin
      if (ap_rd) begin
        SRAMCS   = 1'b1;
        SRAMADDR = HADDR[AW-1:2];
      end else if (dp_wr) begin
        SRAMCS    = 1'b1;
        SRAMWEN   = dp_mask;
        SRAMADDR  = dp_addr;
        SRAMWDATA = HWDATA;
      end else if (buf_valid) begin
        SRAMCS     = 1'b1;
        SRAMWEN    = buf_mask;
        SRAMADDR   = buf_addr;
        SRAMWDATA  = buf_data;
        buf_commit = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_rd     <= 1'b0;
      dp_wr     <= 1'b0;
      dp_addr   <= '0;
      dp_mask   <= '0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_mask  <= '0;
      buf_data  <= '0;
    end else begin
      // Another slave stalling the bus freezes our data phase.
      if (HREADY) begin
        dp_rd   <= ap_rd;
        dp_wr   <= ap_wr;
        dp_addr <= HADDR[AW-1:2];
        dp_mask <= ahb_byte_mask(HSIZE, HADDR[1:0]);
      end
      // A write data phase can only lose the port to a read, and that cycle
      // cannot also drain the buffer, so loading never overwrites a live entry.
      if (ap_rd && dp_wr) begin
        buf_valid <= 1'b1;
        buf_addr  <= dp_addr;
        buf_mask  <= dp_mask;
        buf_data  <= HWDATA;
      end else if (buf_commit) begin
        buf_valid <= 1'b0;
      end
    end
  end

  assign buf_hit = buf_valid && (buf_addr == dp_addr);

  // The SRAM still holds stale data for any parked bytes of this word.
  always_comb begin
    HRDATA = '0;
    if (dp_rd && !HRESET) begin
      HRDATA = SRAMRDATA;
      for (int i = 0; i < 4; i++)
        if (buf_hit && buf_mask[i]) HRDATA[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
module tb_ahbl_sram_ctrl;
  import ahbl_sram_ctrl_pkg::*;

  localparam int AW = 14;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   SRAMRDATA;
  logic [3:0]    SRAMWEN;
  logic [31:0]   SRAMWDATA;
  logic          SRAMCS;
  logic [AW-3:0] SRAMADDR;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1 << (AW-2)];

  ahbl_sram_ctrl #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .SRAMRDATA(SRAMRDATA), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA),
    .SRAMCS(SRAMCS), .SRAMADDR(SRAMADDR)
  );

  always #5 HCLK = ~HCLK;

  // Behavioral SRAM macro: synchronous write, registered read.
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
      else
        for (int b = 0; b < 4; b++)
          if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
    end
  end

  // A data-phase write and a parked write must never coexist.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      checks++;
      if (dut.dp_wr && dut.buf_valid) begin
        errors++;
        $display("FAIL invariant dp_wr=%b buf_valid=%b required not both 1", dut.dp_wr, dut.buf_valid);
      end
    end
  end

  // One bus cycle: address-phase controls plus HWDATA for the previous phase.
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic rdy);
    @(negedge HCLK);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = addr;
    HWDATA = wdata; HREADY = rdy;
    #1;
  endtask

  task automatic idle(input logic [31:0] wdata);
    cyc(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wdata, 1'b1);
  endtask

  task automatic rd(input logic [31:0] addr);
    cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, addr, 32'h0, 1'b1);
  endtask

  task automatic test_reset;
    HRESET = 1'b1;
    // Read request during reset must not reach the SRAM.
    cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h100, 32'h0, 1'b1);
    checks++;
    if (SRAMCS !== 1'b0) begin errors++; $display("FAIL rst_cs got %b exp 0", SRAMCS); end
    idle(32'h0);
    HRESET = 1'b0;
    idle(32'h0);
    checks++;
    if ({HREADYOUT, HRESP, SRAMCS, SRAMWEN} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      errors++; $display("FAIL rst_outs rdyout=%b resp=%b cs=%b wen=%h exp 1 0 0 0", HREADYOUT, HRESP, SRAMCS, SRAMWEN);
    end
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", HRDATA); end
  endtask

  task automatic test_word_write;
    cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h100, 32'h0, 1'b1);
    idle(32'hDEADBEEF);
    checks++;
    if ({SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA} !== {1'b1, 4'hF, 12'h040, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_port cs=%b wen=%h addr=%h wdata=%h exp 1 f 040 deadbeef", SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA);
    end
    idle(32'h0);
    rd(32'h100);
    checks++;
    if ({SRAMCS, SRAMWEN, SRAMADDR} !== {1'b1, 4'h0, 12'h040}) begin
      errors++; $display("FAIL rd_port cs=%b wen=%h addr=%h exp 1 0 040", SRAMCS, SRAMWEN, SRAMADDR);
    end
    idle(32'h0);
    checks++;
    if (HRDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rd got %h exp deadbeef", HRDATA); end
    checks++;
    if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL readyout got %b exp 1", HREADYOUT); end
  endtask

  task automatic test_sub_word;
    cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h201, 32'h0, 1'b1);
    cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h202, 32'h0000_1100, 1'b1);
    checks++;
    if (SRAMWEN !== 4'b0010) begin errors++; $display("FAIL byte_wen got %b exp 0010", SRAMWEN); end
    idle(32'hAABB_0000);
    checks++;
    if (SRAMWEN !== 4'b1100) begin errors++; $display("FAIL half_wen got %b exp 1100", SRAMWEN); end
    rd(32'h200);
    idle(32'h0);
    checks++;
    if (HRDATA !== 32'hAABB1180) begin errors++; $display("FAIL sub_word_rd got %h exp aabb1180", HRDATA); end
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h300, 32'h0, 1'b1);
    cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h300, 32'h12345678, 1'b1);
    checks++;
    if ({SRAMCS, SRAMWEN} !== {1'b1, 4'h0}) begin
      errors++; $display("FAIL b2b_rd_wins cs=%b wen=%h exp 1 0", SRAMCS, SRAMWEN);
    end
    idle(32'h0);
    checks++;
    if (dut.buf_valid !== 1'b1) begin errors++; $display("FAIL b2b_buf_valid got %b exp 1", dut.buf_valid); end
    checks++;
    if (HRDATA !== 32'h12345678) begin errors++; $display("FAIL b2b_merge got %h exp 12345678", HRDATA); end
    checks++;
    if ({SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA} !== {1'b1, 4'hF, 12'h0C0, 32'h12345678}) begin
      errors++; $display("FAIL b2b_drain cs=%b wen=%h addr=%h wdata=%h exp 1 f 0c0 12345678", SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA);
    end
    rd(32'h300);
    idle(32'h0);
    checks++;
    if (HRDATA !== 32'h12345678) begin errors++; $display("FAIL b2b_reread got %h exp 12345678", HRDATA); end
  endtask

  task automatic test_held_buffer;
    cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h300, 32'h0, 1'b1);
    cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h304, 32'hCAFEF00D, 1'b1);
    for (int k = 0; k < 4; k++) begin
      rd(32'h304);
      checks++;
      if ({SRAMWEN, dut.buf_valid} !== {4'h0, 1'b1}) begin
        errors++; $display("FAIL held_%0d wen=%h buf_valid=%b exp 0 1", k, SRAMWEN, dut.buf_valid);
      end
    end
    idle(32'h0);
    checks++;
    if (HRDATA !== 32'hA50000C1) begin errors++; $display("FAIL held_rd got %h exp a50000c1", HRDATA); end
    checks++;
    if ({SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA} !== {1'b1, 4'hF, 12'h0C0, 32'hCAFEF00D}) begin
      errors++; $display("FAIL held_drain cs=%b wen=%h addr=%h wdata=%h exp 1 f 0c0 cafef00d", SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA);
    end
    rd(32'h300);
    idle(32'h0);
    checks++;
    if (HRDATA !== 32'hCAFEF00D) begin errors++; $display("FAIL held_reread got %h exp cafef00d", HRDATA); end
  endtask

  task automatic test_hready_low;
    cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h400, 32'h0, 1'b0);
    checks++;
    if (SRAMCS !== 1'b0) begin errors++; $display("FAIL stall_ap_cs got %b exp 0", SRAMCS); end
    idle(32'h11111111);
    checks++;
    if ({SRAMCS, dut.dp_wr} !== 2'b00) begin
      errors++; $display("FAIL stall_dp cs=%b dp_wr=%b exp 0 0", SRAMCS, dut.dp_wr);
    end
  endtask

  task automatic test_reset_discard;
    cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h500, 32'h0, 1'b1);
    cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h500, 32'h0BADF00D, 1'b1);
    HRESET = 1'b1;
    idle(32'h0);
    checks++;
    if ({SRAMCS, SRAMWEN} !== {1'b0, 4'h0}) begin
      errors++; $display("FAIL in_rst_port cs=%b wen=%h exp 0 0", SRAMCS, SRAMWEN);
    end
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("FAIL in_rst_hrdata got %h exp 0", HRDATA); end
    HRESET = 1'b0;
    idle(32'h0);
    checks++;
    if ({SRAMCS, HRDATA, dut.buf_valid} !== {1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL post_rst cs=%b hrdata=%h buf_valid=%b exp 0 0 0", SRAMCS, HRDATA, dut.buf_valid);
    end
    rd(32'h500);
    idle(32'h0);
    checks++;
    if (HRDATA !== 32'hA5000140) begin errors++; $display("FAIL discard_rd got %h exp a5000140", HRDATA); end
  endtask

  initial begin
    for (int i = 0; i < (1 << (AW-2)); i++) mem[i] = 32'hA500_0000 | i;
    SRAMRDATA = 32'h0;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0; HSIZE = HSIZE_WORD; HREADY = 1'b1; HWDATA = 32'h0;
    test_reset();
    test_word_write();
    test_sub_word();
    test_back_to_back();
    test_held_buffer();
    test_hready_low();
    test_reset_discard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
